// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake, IM write port and load status for instr_encoder.
interface instr_encoder_if #(
    parameter int DEPTH = 1024
) ();
    localparam int CW = $clog2(DEPTH + 1);

    // Field bundle, valid/ready handshake
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [5:0]    opCode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    func;
    logic [15:0]   imm;
    logic [25:0]   index;
    logic [31:0]   raw;
    logic          finish;

    // Instruction-memory write request, held until acknowledged
    logic          im_we;
    logic [31:0]   im_addr;
    logic [31:0]   im_wdata;
    logic          im_ack;

    // Load status
    logic [CW-1:0] count;
    logic          done;
    logic          err;

    modport master (
        output in_valid, fmt, opCode, rs, rt, rd, shamt, func, imm, index, raw, finish, im_ack,
        input  in_ready, im_we, im_addr, im_wdata, count, done, err
    );

    modport slave (
        input  in_valid, fmt, opCode, rs, rt, rd, shamt, func, imm, index, raw, finish, im_ack,
        output in_ready, im_we, im_addr, im_wdata, count, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles MIPS instruction words from R/I/J/raw field bundles and streams
// them into instruction memory at consecutive word addresses from BASE_ADDR.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    logic [1:0]    r_state;
    logic          r_im_we;
    logic [31:0]   r_im_addr;
    logic [31:0]   r_im_wdata;
    logic [CW-1:0] r_count;
    logic          r_done;
    logic          r_err;
    logic          r_pending_finish;

    logic [31:0]   w_word;
    logic          w_full;
    logic          w_in_ready;
    logic          w_accept;
    logic [31:0]   w_next_addr;

    // Assemble the instruction word for the selected format; unused fields are ignored.
    always_comb begin
        // NOTE: default first so every path assigns w_word and no latch is inferred.
        w_word = bus.raw;
        case (bus.fmt)
            FMT_R:   w_word = {bus.opCode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
            FMT_I:   w_word = {bus.opCode, bus.rs, bus.rt, bus.imm};
            FMT_J:   w_word = {bus.opCode, bus.index};
            default: w_word = bus.raw;
        endcase
    end

    // count never exceeds DEPTH, so "full" is the same test as !(count < DEPTH).
    assign w_full      = (r_count == LP_DEPTH);
    // Moore ready: depends on state only, held low while reset is asserted.
    assign w_in_ready  = (r_state == ST_IDLE) && !w_full && !r_done && !reset;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_next_addr = BASE_ADDR + (32'(r_count) << 2);

    // Load sequencer: accept a bundle in IDLE, hold the IM write in WRITE until ack, park in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state          <= ST_IDLE;
            r_im_we          <= 1'b0;
            r_im_addr        <= BASE_ADDR;
            r_im_wdata       <= 32'h0;
            r_count          <= '0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_pending_finish <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_im_wdata       <= w_word;
                        r_im_addr        <= w_next_addr;
                        r_im_we          <= 1'b1;
                        r_state          <= ST_WRITE;
                        r_pending_finish <= bus.finish;
                    end else if (bus.finish && !r_pending_finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                    // A push against a full memory is refused and flagged.
                    if (bus.in_valid && w_full) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus.im_ack) begin
                        r_count          <= r_count + CW'(1);
                        r_im_we          <= 1'b0;
                        r_pending_finish <= 1'b0;
                        if (r_pending_finish || bus.finish) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.finish) begin
                        r_pending_finish <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_im_we <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_im_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.im_we    = r_im_we;
    assign bus.im_addr  = r_im_addr;
    assign bus.im_wdata = r_im_wdata;
    assign bus.count    = r_count;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule
